// File: rtl/jedro_1_decoder_pkg.sv
// Shared constants for the jedro_1 decode stage: RV32I opcodes handled here and the ALU opcode map.
package jedro_1_decoder_pkg;

    localparam int unsigned ALU_OP_WIDTH = 4;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;

    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_ADD  = 4'b0000;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SUB  = 4'b1000;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLL  = 4'b0001;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLT  = 4'b0010;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLTU = 4'b0011;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_XOR  = 4'b0100;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SRL  = 4'b0101;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SRA  = 4'b1101;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_OR   = 4'b0110;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_AND  = 4'b0111;

    // ALU opcode is the alternate-encoding bit on top of funct3
    function automatic logic [ALU_OP_WIDTH-1:0] alu_op_of(input logic alt, input logic [2:0] funct3);
        return {alt, funct3};
    endfunction

endpackage

// File: rtl/jedro_1_imm_gen.sv
// Immediate extraction for the jedro_1 decoder: sign-extended I-imm, U-imm and zero-extended shamt.
module jedro_1_imm_gen #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [19:0]           imm_field,
    output logic [DATA_WIDTH-1:0] i_imm_c,
    output logic [DATA_WIDTH-1:0] u_imm_c,
    output logic [DATA_WIDTH-1:0] shamt_c
);

    // imm_field is instr[31:12]; I-imm lives in its top 12 bits, shamt in instr[24:20]
    assign i_imm_c = {{(DATA_WIDTH-12){imm_field[19]}}, imm_field[19:8]};
    assign u_imm_c = {imm_field, 12'b0};
    assign shamt_c = DATA_WIDTH'(imm_field[12:8]);

endmodule

// File: rtl/jedro_1_decoder.sv
// jedro_1 decode stage: RV32I OP/OP-IMM/LUI/AUIPC to registered ALU operands, RAW stall, illegal flag.
// Define JEDRO_1_DECODER_BYPASS_EN to forward alu_res_i on a RAW hit instead of stalling.
module jedro_1_decoder
    import jedro_1_decoder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [31:0]             instr_i,
    input  logic [DATA_WIDTH-1:0]   pc_i,
    input  logic                    instr_valid_i,
    output logic                    instr_ready_o,
    output logic [REG_ADDR_W-1:0]   rs1_addr_o,
    output logic [REG_ADDR_W-1:0]   rs2_addr_o,
    input  logic [DATA_WIDTH-1:0]   rs1_data_i,
    input  logic [DATA_WIDTH-1:0]   rs2_data_i,
`ifdef JEDRO_1_DECODER_BYPASS_EN
    input  logic [DATA_WIDTH-1:0]   alu_res_i,
`endif
    output logic [ALU_OP_WIDTH-1:0] alu_op_sel_o,
    output logic [DATA_WIDTH-1:0]   alu_opa_o,
    output logic [DATA_WIDTH-1:0]   alu_opb_o,
    output logic [REG_ADDR_W-1:0]   rd_addr_o,
    output logic                    rd_we_o,
    output logic                    illegal_instr_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i
);

    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [REG_ADDR_W-1:0] rd_addr;

    assign opcode     = instr_i[6:0];
    assign funct3     = instr_i[14:12];
    assign funct7     = instr_i[31:25];
    assign rd_addr    = REG_ADDR_W'(instr_i[11:7]);
    assign rs1_addr_o = REG_ADDR_W'(instr_i[19:15]);
    assign rs2_addr_o = REG_ADDR_W'(instr_i[24:20]);

    logic [DATA_WIDTH-1:0] i_imm;
    logic [DATA_WIDTH-1:0] u_imm;
    logic [DATA_WIDTH-1:0] shamt;

    jedro_1_imm_gen #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_imm_gen (
        .imm_field (instr_i[31:12]),
        .i_imm_c   (i_imm),
        .u_imm_c   (u_imm),
        .shamt_c   (shamt)
    );

    // RAW detection against the instruction held in the output stage
    logic uses_rs1;
    logic uses_rs2;
    logic match_rs1;
    logic match_rs2;

    assign uses_rs1  = (opcode == OPCODE_OP) | (opcode == OPCODE_OP_IMM);
    assign uses_rs2  = (opcode == OPCODE_OP);
    assign match_rs1 = out_valid_o & rd_we_o & uses_rs1 & (rs1_addr_o == rd_addr_o);
    assign match_rs2 = out_valid_o & rd_we_o & uses_rs2 & (rs2_addr_o == rd_addr_o);

    logic [DATA_WIDTH-1:0] rs1_val;
    logic [DATA_WIDTH-1:0] rs2_val;

`ifdef JEDRO_1_DECODER_BYPASS_EN
    // A matching operand takes the ALU result of the held instruction, which retires this edge
    assign rs1_val       = match_rs1 ? alu_res_i : rs1_data_i;
    assign rs2_val       = match_rs2 ? alu_res_i : rs2_data_i;
    assign instr_ready_o = ~rst_i & (~out_valid_o | out_ready_i);
`else
    assign rs1_val       = rs1_data_i;
    assign rs2_val       = rs2_data_i;
    assign instr_ready_o = ~rst_i & (~out_valid_o | (out_ready_i & ~(match_rs1 | match_rs2)));
`endif

    // Instruction decode and operand selection
    logic                    legal;
    logic [ALU_OP_WIDTH-1:0] dec_op;
    logic [DATA_WIDTH-1:0]   dec_opa;
    logic [DATA_WIDTH-1:0]   dec_opb;

    always_comb begin
        legal   = 1'b0;
        dec_op  = ALU_OP_ADD;
        dec_opa = '0;
        dec_opb = '0;
        case (opcode)
            OPCODE_OP: begin
                legal   = (funct7 == 7'h00) |
                          ((funct7 == 7'h20) & ((funct3 == 3'b000) | (funct3 == 3'b101)));
                dec_op  = alu_op_of(funct7[5], funct3);
                dec_opa = rs1_val;
                dec_opb = rs2_val;
            end
            OPCODE_OP_IMM: begin
                dec_opa = rs1_val;
                case (funct3)
                    3'b001: begin
                        legal   = (funct7 == 7'h00);
                        dec_op  = alu_op_of(1'b0, funct3);
                        dec_opb = shamt;
                    end
                    3'b101: begin
                        legal   = (funct7 == 7'h00) | (funct7 == 7'h20);
                        dec_op  = alu_op_of(funct7[5], funct3);
                        dec_opb = shamt;
                    end
                    default: begin
                        legal   = 1'b1;
                        dec_op  = alu_op_of(1'b0, funct3);
                        dec_opb = i_imm;
                    end
                endcase
            end
            OPCODE_LUI: begin
                legal   = 1'b1;
                dec_opb = u_imm;
            end
            OPCODE_AUIPC: begin
                legal   = 1'b1;
                dec_opa = pc_i;
                dec_opb = u_imm;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            dec_op  = ALU_OP_ADD;
            dec_opa = '0;
            dec_opb = '0;
        end
    end

    // Output stage next-state
    logic                    load;
    logic                    out_valid_d;
    logic [ALU_OP_WIDTH-1:0] op_d;
    logic [DATA_WIDTH-1:0]   opa_d;
    logic [DATA_WIDTH-1:0]   opb_d;
    logic [REG_ADDR_W-1:0]   rd_d;
    logic                    we_d;
    logic                    ill_d;

    assign load = instr_valid_i & instr_ready_o;

    always_comb begin
        out_valid_d = out_valid_o;
        op_d        = alu_op_sel_o;
        opa_d       = alu_opa_o;
        opb_d       = alu_opb_o;
        rd_d        = rd_addr_o;
        we_d        = rd_we_o;
        ill_d       = illegal_instr_o;
        if (load) begin
            out_valid_d = 1'b1;
            op_d        = dec_op;
            opa_d       = dec_opa;
            opb_d       = dec_opb;
            rd_d        = rd_addr;
            we_d        = legal & (rd_addr != '0);
            ill_d       = ~legal;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_o     <= 1'b0;
            alu_op_sel_o    <= ALU_OP_ADD;
            alu_opa_o       <= '0;
            alu_opb_o       <= '0;
            rd_addr_o       <= '0;
            rd_we_o         <= 1'b0;
            illegal_instr_o <= 1'b0;
        end else begin
            out_valid_o     <= out_valid_d;
            alu_op_sel_o    <= op_d;
            alu_opa_o       <= opa_d;
            alu_opb_o       <= opb_d;
            rd_addr_o       <= rd_d;
            rd_we_o         <= we_d;
            illegal_instr_o <= ill_d;
        end
    end

endmodule

// File: tb/tb_jedro_1_decoder.sv
// Randomized self-checking bench for jedro_1_decoder against a behavioural RV32I decode model.
// Honours JEDRO_1_DECODER_BYPASS_EN when defined.
module tb_jedro_1_decoder;

`ifdef JEDRO_1_DECODER_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr, pc, rs1_data, rs2_data, alu_res;
    logic        instr_valid, out_ready;
    logic        instr_ready;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [3:0]  alu_op;
    logic [31:0] opa, opb;
    logic        rd_we, illegal, out_valid;

    always #5 clk = ~clk;

    jedro_1_decoder dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .instr_i         (instr),
        .pc_i            (pc),
        .instr_valid_i   (instr_valid),
        .instr_ready_o   (instr_ready),
        .rs1_addr_o      (rs1_addr),
        .rs2_addr_o      (rs2_addr),
        .rs1_data_i      (rs1_data),
        .rs2_data_i      (rs2_data),
`ifdef JEDRO_1_DECODER_BYPASS_EN
        .alu_res_i       (alu_res),
`endif
        .alu_op_sel_o    (alu_op),
        .alu_opa_o       (opa),
        .alu_opb_o       (opb),
        .rd_addr_o       (rd_addr),
        .rd_we_o         (rd_we),
        .illegal_instr_o (illegal),
        .out_valid_o     (out_valid),
        .out_ready_i     (out_ready)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model of the output stage
    logic        m_valid = 1'b0, m_we = 1'b0, m_ill = 1'b0;
    logic [3:0]  m_op = 4'd0;
    logic [31:0] m_opa = '0, m_opb = '0;
    logic [4:0]  m_rd = '0;

    typedef struct packed {
        logic        legal;
        logic [3:0]  op;
        logic [31:0] opa;
        logic [31:0] opb;
    } ref_t;

    function automatic logic reads_rs1(input logic [31:0] ins);
        return (ins[6:0] == 7'h33) || (ins[6:0] == 7'h13);
    endfunction

    function automatic logic reads_rs2(input logic [31:0] ins);
        return ins[6:0] == 7'h33;
    endfunction

    function automatic logic raw_rs1();
        return m_valid && m_we && reads_rs1(instr) && (instr[19:15] == m_rd);
    endfunction

    function automatic logic raw_rs2();
        return m_valid && m_we && reads_rs2(instr) && (instr[24:20] == m_rd);
    endfunction

    function automatic logic model_ready();
        if (rst) return 1'b0;
        if (BYPASS) return !m_valid || out_ready;
        return !m_valid || (out_ready && !(raw_rs1() || raw_rs2()));
    endfunction

    function automatic ref_t model_decode();
        ref_t        r;
        logic [31:0] a, b, simm, uimm, sh;
        logic [2:0]  f3;
        logic [6:0]  f7;
        a    = (BYPASS && raw_rs1()) ? alu_res : rs1_data;
        b    = (BYPASS && raw_rs2()) ? alu_res : rs2_data;
        f3   = instr[14:12];
        f7   = instr[31:25];
        simm = 32'($signed(instr[31:20]));
        uimm = instr & 32'hFFFFF000;
        sh   = 32'(instr[24:20]);
        r    = '0;
        case (instr[6:0])
            7'h33: begin
                r.legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
                r.op    = 4'(f3) + (f7 == 7'h20 ? 4'd8 : 4'd0);
                r.opa   = a;
                r.opb   = b;
            end
            7'h13: begin
                r.opa = a;
                if (f3 == 3'd1) begin
                    r.legal = (f7 == 7'h00);
                    r.op    = 4'd1;
                    r.opb   = sh;
                end else if (f3 == 3'd5) begin
                    r.legal = (f7 == 7'h00) || (f7 == 7'h20);
                    r.op    = (f7 == 7'h20) ? 4'd13 : 4'd5;
                    r.opb   = sh;
                end else begin
                    r.legal = 1'b1;
                    r.op    = 4'(f3);
                    r.opb   = simm;
                end
            end
            7'h37: begin r.legal = 1'b1; r.opb = uimm; end
            7'h17: begin r.legal = 1'b1; r.opa = pc; r.opb = uimm; end
            default: r.legal = 1'b0;
        endcase
        if (!r.legal) begin
            r.op  = 4'd0;
            r.opa = '0;
            r.opb = '0;
        end
        return r;
    endfunction

    task automatic apply(input logic [31:0] ins, input logic v, input logic ordy, input logic r,
                         input logic [31:0] a, input logic [31:0] b);
        instr       = ins;
        instr_valid = v;
        out_ready   = ordy;
        rst         = r;
        rs1_data    = a;
        rs2_data    = b;
        pc          = $urandom;
        alu_res     = $urandom;
    endtask

    // One clock: combinational checks, model update at the edge, registered checks after it
    task automatic step();
        ref_t d;
        logic rdy;
        #1;
        rdy = model_ready();
        check("instr_ready", 32'(instr_ready), 32'(rdy));
        check("rs1_addr", 32'(rs1_addr), 32'(instr[19:15]));
        check("rs2_addr", 32'(rs2_addr), 32'(instr[24:20]));
        @(posedge clk);
        d = model_decode();
        if (rst) begin
            m_valid = 1'b0; m_we = 1'b0; m_ill = 1'b0;
            m_op = 4'd0; m_opa = '0; m_opb = '0; m_rd = '0;
        end else if (instr_valid && rdy) begin
            m_valid = 1'b1;
            m_ill   = !d.legal;
            m_rd    = instr[11:7];
            m_we    = d.legal && (instr[11:7] != 5'd0);
            m_op    = d.op;
            m_opa   = d.opa;
            m_opb   = d.opb;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        #1;
        check("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid) begin
            check("illegal", 32'(illegal), 32'(m_ill));
            check("rd_we", 32'(rd_we), 32'(m_we));
            check("alu_op", 32'(alu_op), 32'(m_op));
            check("opa", opa, m_opa);
            check("opb", opb, m_opb);
            if (!m_ill) check("rd_addr", 32'(rd_addr), 32'(m_rd));
        end
        @(negedge clk);
    endtask

    task automatic expect_stage(input string tag, input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [4:0] rd, input logic we,
                                input logic ill);
        check({tag, ".valid"}, 32'(out_valid), 32'(1));
        check({tag, ".op"}, 32'(alu_op), 32'(op));
        check({tag, ".opa"}, opa, a);
        check({tag, ".opb"}, opb, b);
        if (!ill) check({tag, ".rd"}, 32'(rd_addr), 32'(rd));
        check({tag, ".we"}, 32'(rd_we), 32'(we));
        check({tag, ".ill"}, 32'(illegal), 32'(ill));
    endtask

    // Drain the stage, then issue one instruction with out_ready high
    task automatic directed(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        apply(32'h0000_0013, 1'b0, 1'b1, 1'b0, '0, '0);
        step();
        apply(ins, 1'b1, 1'b1, 1'b0, a, b);
        step();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int          k;
        int          f;
        w = $urandom;
        k = $urandom_range(0, 9);
        f = $urandom_range(0, 5);
        if (k < 9) begin
            w[11:7]  = 5'($urandom_range(0, 3));
            w[19:15] = 5'($urandom_range(0, 3));
            w[24:20] = 5'($urandom_range(0, 3));
            if (f < 3)      w[31:25] = 7'h00;
            else if (f < 5) w[31:25] = 7'h20;
        end
        if (k < 4)      w[6:0] = 7'h33;
        else if (k < 7) w[6:0] = 7'h13;
        else if (k < 8) w[6:0] = 7'h37;
        else if (k < 9) w[6:0] = 7'h17;
        return w;
    endfunction

    initial begin
        apply('0, 1'b0, 1'b0, 1'b1, '0, '0);
        step();
        step();
        check("rst.valid", 32'(out_valid), 32'(0));
        check("rst.we", 32'(rd_we), 32'(0));
        check("rst.ill", 32'(illegal), 32'(0));
        check("rst.op", 32'(alu_op), 32'(0));
        check("rst.opa", opa, 32'd0);
        check("rst.opb", opb, 32'd0);
        check("rst.rd", 32'(rd_addr), 32'(0));

        directed(32'hFFB1_0093, 32'd10, 32'd0);
        expect_stage("addi", 4'b0000, 32'd10, 32'hFFFF_FFFB, 5'd1, 1'b1, 1'b0);
        directed(32'h4020_81B3, 32'd7, 32'd9);
        expect_stage("sub", 4'b1000, 32'd7, 32'd9, 5'd3, 1'b1, 1'b0);
        directed(32'h4032_D293, 32'd40, 32'd0);
        expect_stage("srai", 4'b1101, 32'd40, 32'd3, 5'd5, 1'b1, 1'b0);
        directed(32'h1234_53B7, 32'd1, 32'd2);
        expect_stage("lui", 4'b0000, 32'd0, 32'h1234_5000, 5'd7, 1'b1, 1'b0);
        directed(32'h0000_0000, 32'd1, 32'd2);
        expect_stage("ill0", 4'b0000, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
        directed(32'hFE00_00B3, 32'd1, 32'd2);
        expect_stage("ill7f", 4'b0000, 32'd0, 32'd0, 5'd1, 1'b0, 1'b1);

        // RAW: ADDI x1 held, then ADD x4,x1,x1
        apply(32'h0, 1'b0, 1'b1, 1'b0, '0, '0);
        step();
        apply(32'hFFB1_0093, 1'b1, 1'b0, 1'b0, 32'd10, '0);
        step();
        apply(32'h0010_8233, 1'b1, 1'b0, 1'b0, 32'd20, 32'd30);
        #1 check("raw.stall", 32'(instr_ready), 32'(0));
        step();
        apply(32'h0010_8233, 1'b1, 1'b1, 1'b0, 32'd20, 32'd30);
        alu_res = 32'h0000_0055;
        #1 check("raw.pulse", 32'(instr_ready), 32'(BYPASS));
        step();
        if (BYPASS) begin
            expect_stage("raw.fwd", 4'b0000, 32'h55, 32'h55, 5'd4, 1'b1, 1'b0);
        end else begin
            apply(32'h0010_8233, 1'b1, 1'b1, 1'b0, 32'd20, 32'd30);
            #1 check("raw.retry", 32'(instr_ready), 32'(1));
            step();
            expect_stage("raw.add", 4'b0000, 32'd20, 32'd30, 5'd4, 1'b1, 1'b0);
        end

        // Held stage under backpressure, then reset while valid
        for (int i = 0; i < 5; i++) begin
            apply(rand_instr(), 1'b1, 1'b0, 1'b0, $urandom, $urandom);
            step();
        end
        apply(rand_instr(), 1'b1, 1'b1, 1'b1, $urandom, $urandom);
        step();
        check("rst.mid", 32'(out_valid), 32'(0));

        for (int i = 0; i < 3000; i++) begin
            apply(rand_instr(), ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) < 5),
                  ($urandom_range(0, 63) == 0), $urandom, $urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
